pipe_hazard_ctrl: RTL and testbench

Central pipeline controller for the 5-stage core (F, D, E, R/mem, RB/writeback).
- Tracks destinations of in-flight instructions in a 3-entry scoreboard.
- Produces forwarding selects, load-use stalls, branch/jump flushes and halt/single-step sequencing.
- Replaces the combinational register-compare logic in the core.
- Sits between the decode stage and the pipeline-register enables.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 45 ++++
 rtl/pipe_hazard_ctrl_scoreboard.sv | 63 ++++++
 rtl/pipe_hazard_ctrl.sv | 133 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects, FSM states, scoreboard entries.
// Pure declarations; no latency or backpressure of its own.
package pipe_hazard_ctrl_pkg;

  // Entry dst field is sized for the widest register index the core may use.
  localparam int SB_DST_W = 8;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_RB = 2'b01,
    FWD_R  = 2'b10,
    FWD_E  = 2'b11
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED,
    STEP
  } ctrl_state_e;

  typedef struct packed {
    logic                valid;
    logic                wr;
    logic                load;
    logic [SB_DST_W-1:0] dst;
  } sb_entry_t;

  function automatic logic sb_match(input sb_entry_t ent,
                                    input logic [SB_DST_W-1:0] src,
                                    input logic use_src);
    return ent.valid && ent.wr && use_src && (src != '0) && (ent.dst == src);
  endfunction

  // Youngest producer wins; a load still in E has no data yet and is skipped.
  function automatic fwd_sel_e fwd_pick(input sb_entry_t e_ent, r_ent, rb_ent,
                                        input logic [SB_DST_W-1:0] src,
                                        input logic use_src);
    if (sb_match(e_ent, src, use_src) && !e_ent.load) return FWD_E;
    if (sb_match(r_ent, src, use_src))                return FWD_R;
    if (sb_match(rb_ent, src, use_src))               return FWD_RB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
// 3-entry in-flight destination scoreboard (e, r, rb) with operand-forwarding selects and load-use detect.
// Selects/hazard are combinational from registered entries; shifts one slot per enabled cycle, holds when en=0.
module hazard_scoreboard
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             bubble,
  input  logic             d_valid,
  input  logic [REG_W-1:0] d_rs,
  input  logic [REG_W-1:0] d_rt,
  input  logic             d_use_rs,
  input  logic             d_use_rt,
  input  logic             d_wr,
  input  logic [REG_W-1:0] d_dst,
  input  logic             d_load,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             load_hazard,
  output logic             drain_done
);

  sb_entry_t           e_ent, r_ent, rb_ent, e_nxt;
  logic [SB_DST_W-1:0] rs_x, rt_x;

  assign rs_x = SB_DST_W'(d_rs);
  assign rt_x = SB_DST_W'(d_rt);

  always_comb begin
    e_nxt = '0;
    if (d_valid && !bubble) begin
      e_nxt.valid = 1'b1;
      e_nxt.wr    = d_wr;
      e_nxt.load  = d_load;
      e_nxt.dst   = SB_DST_W'(d_dst);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e_ent  <= '0;
      r_ent  <= '0;
      rb_ent <= '0;
    end else if (en) begin
      rb_ent <= r_ent;
      r_ent  <= e_ent;
      e_ent  <= e_nxt;
    end
  end

  assign fwd_a = fwd_pick(e_ent, r_ent, rb_ent, rs_x, d_use_rs);
  assign fwd_b = fwd_pick(e_ent, r_ent, rb_ent, rt_x, d_use_rt);

  assign load_hazard = e_ent.load &&
                       (sb_match(e_ent, rs_x, d_use_rs) || sb_match(e_ent, rt_x, d_use_rt));

  // While draining E is always refilled with a bubble, so the pipe is empty after this edge.
  assign drain_done = !e_ent.valid && !r_ent.valid;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline controller: forwarding, load-use stall, branch/jump flush, halt/single-step sequencing.
// Control outputs are combinational in the decode cycle; stalls hold PC and F->D for one cycle per load-use.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d_valid,
  input  logic [REG_W-1:0] d_rs,
  input  logic [REG_W-1:0] d_rt,
  input  logic             d_use_rs,
  input  logic             d_use_rt,
  input  logic             d_wr,
  input  logic [REG_W-1:0] d_dst,
  input  logic             d_load,
  input  logic             d_jmp,
  input  logic             e_br_taken,
  input  logic             halt_req,
  input  logic             step_req,
  output logic             pc_en,
  output logic             fd_en,
  output logic             fd_flush,
  output logic             de_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             halt_ack,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  ctrl_state_e      state, state_nxt;
  logic             load_hazard, drain_done;
  logic             stall, branch, jump, sb_en;
  logic [CNT_W:0]   flush_sum;

  hazard_scoreboard #(.REG_W(REG_W)) u_sb (
    .clk         (clk),
    .rst         (rst),
    .en          (sb_en),
    .bubble      (de_bubble),
    .d_valid     (d_valid),
    .d_rs        (d_rs),
    .d_rt        (d_rt),
    .d_use_rs    (d_use_rs),
    .d_use_rt    (d_use_rt),
    .d_wr        (d_wr),
    .d_dst       (d_dst),
    .d_load      (d_load),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .load_hazard (load_hazard),
    .drain_done  (drain_done)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pc_en     = 1'b1;
    fd_en     = 1'b1;
    fd_flush  = 1'b0;
    de_bubble = 1'b0;
    halt_ack  = 1'b0;
    sb_en     = 1'b1;
    stall     = 1'b0;
    branch    = 1'b0;
    jump      = 1'b0;
    case (state)
      RUN: begin
        branch = e_br_taken;
        stall  = load_hazard && !e_br_taken;
        jump   = d_jmp && !e_br_taken && !load_hazard;
        if (halt_req) state_nxt = DRAIN;
      end
      DRAIN: begin
        branch    = e_br_taken;
        pc_en     = 1'b0;
        fd_en     = 1'b0;
        de_bubble = 1'b1;
        if (drain_done) state_nxt = HALTED;
      end
      HALTED: begin
        pc_en     = 1'b0;
        fd_en     = 1'b0;
        de_bubble = 1'b1;
        sb_en     = 1'b0;
        halt_ack  = 1'b1;
        if (step_req)      state_nxt = STEP;
        else if (!halt_req) state_nxt = RUN;
      end
      STEP: begin
        branch    = e_br_taken;
        stall     = load_hazard && !e_br_taken;
        jump      = d_jmp && !e_br_taken && !load_hazard;
        state_nxt = stall ? STEP : DRAIN;
      end
      default: state_nxt = RUN;
    endcase
    if (stall) begin
      pc_en     = 1'b0;
      fd_en     = 1'b0;
      de_bubble = 1'b1;
    end
    if (jump) fd_flush = 1'b1;
    // A taken branch makes everything younger wrong-path; the target fetch always proceeds.
    if (branch) begin
      pc_en     = 1'b1;
      fd_en     = 1'b1;
      fd_flush  = 1'b1;
      de_bubble = 1'b1;
    end
  end

  assign flush_sum = {1'b0, flush_cnt} +
                     (branch ? (CNT_W+1)'(2) : (jump ? (CNT_W+1)'(1) : (CNT_W+1)'(0)));

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      flush_cnt <= flush_sum[CNT_W] ? '1 : flush_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized plus directed bench for pipe_hazard_ctrl against a slot-list reference model.
// Counters are narrowed so saturation is reached within the run.
module tb_pipe_hazard_ctrl;

  localparam int TB_REG_W = 5;
  localparam int TB_CNT_W = 6;
  localparam int CMAX     = (1 << TB_CNT_W) - 1;
  localparam int M_RUN = 0, M_DRAIN = 1, M_HALTED = 2, M_STEP = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic                d_valid, d_use_rs, d_use_rt, d_wr, d_load, d_jmp;
  logic [TB_REG_W-1:0] d_rs, d_rt, d_dst;
  logic                e_br_taken, halt_req, step_req;
  logic                pc_en, fd_en, fd_flush, de_bubble, halt_ack;
  logic [1:0]          fwd_a, fwd_b;
  logic [TB_CNT_W-1:0] stall_cnt, flush_cnt;

  pipe_hazard_ctrl #(.REG_W(TB_REG_W), .CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst(rst), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
    .d_use_rs(d_use_rs), .d_use_rt(d_use_rt), .d_wr(d_wr), .d_dst(d_dst),
    .d_load(d_load), .d_jmp(d_jmp), .e_br_taken(e_br_taken), .halt_req(halt_req),
    .step_req(step_req), .pc_en(pc_en), .fd_en(fd_en), .fd_flush(fd_flush),
    .de_bubble(de_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b), .halt_ack(halt_ack),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: in-flight instructions, oldest last (0 = in E, 1 = in R, 2 = in RB).
  typedef struct { bit v; bit wr; bit ld; int dst; } slot_t;
  slot_t pipe [3];
  int    mode, m_stall, m_flush;
  bit    x_br, x_st, x_jp, x_bub;

  function automatic bit hits(slot_t s, int src, bit u);
    return s.v && s.wr && u && (src != 0) && (s.dst == src);
  endfunction

  function automatic int pick(int src, bit u);
    for (int i = 0; i < 3; i++)
      if (hits(pipe[i], src, u) && !(i == 0 && pipe[0].ld)) return 3 - i;
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0, 0};
    mode = M_RUN; m_stall = 0; m_flush = 0;
  endtask

  task automatic advance();
    int f;
    if (rst) begin
      model_reset();
      return;
    end
    if (mode != M_HALTED) begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = '{d_valid && !x_bub, d_wr, d_load, int'(d_dst)};
    end
    if (x_st) m_stall = (m_stall + 1 > CMAX) ? CMAX : m_stall + 1;
    f = m_flush + (x_br ? 2 : (x_jp ? 1 : 0));
    m_flush = (f > CMAX) ? CMAX : f;
    case (mode)
      M_RUN:    if (halt_req) mode = M_DRAIN;
      M_DRAIN:  if (!pipe[0].v && !pipe[1].v && !pipe[2].v) mode = M_HALTED;
      M_HALTED: if (step_req) mode = M_STEP; else if (!halt_req) mode = M_RUN;
      default:  mode = x_st ? M_STEP : M_DRAIN;
    endcase
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic tick();
    bit active, lu, en_exp;
    #1;
    active = (mode == M_RUN) || (mode == M_STEP);
    lu     = active && pipe[0].ld &&
             (hits(pipe[0], int'(d_rs), d_use_rs) || hits(pipe[0], int'(d_rt), d_use_rt));
    x_br   = e_br_taken && (mode != M_HALTED);
    x_st   = lu && !x_br;
    x_jp   = active && d_jmp && !x_br && !lu;
    en_exp = x_br || (active && !x_st);
    x_bub  = x_br || x_st || !active;
    chk("pc_en",     pc_en,     en_exp);
    chk("fd_en",     fd_en,     en_exp);
    chk("fd_flush",  fd_flush,  x_br || x_jp);
    chk("de_bubble", de_bubble, x_bub);
    chk("fwd_a",     fwd_a,     pick(int'(d_rs), d_use_rs));
    chk("fwd_b",     fwd_b,     pick(int'(d_rt), d_use_rt));
    chk("halt_ack",  halt_ack,  mode == M_HALTED);
    chk("stall_cnt", stall_cnt, m_stall);
    chk("flush_cnt", flush_cnt, m_flush);
    @(posedge clk);
    advance();
    @(negedge clk);
  endtask

  task automatic set_d(input bit v, input int rs, input bit urs, input int rt, input bit urt,
                       input bit wr, input int dst, input bit ld);
    d_valid = v; d_rs = rs[TB_REG_W-1:0]; d_use_rs = urs; d_rt = rt[TB_REG_W-1:0];
    d_use_rt = urt; d_wr = wr; d_dst = dst[TB_REG_W-1:0]; d_load = ld;
  endtask

  initial begin
    rst = 1'b1; d_jmp = 0; e_br_taken = 0; halt_req = 0; step_req = 0;
    set_d(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    tick();
    rst = 1'b0;
    tick();

    // ALU result forwarded from E, then R, then RB, then regfile.
    set_d(1, 0, 0, 0, 0, 1, 3, 0); tick();
    set_d(1, 3, 1, 0, 0, 0, 0, 0); tick();
    set_d(0, 3, 1, 0, 0, 0, 0, 0); repeat (3) tick();

    // Load-use on rt, then forwarded from R.
    set_d(1, 0, 0, 0, 0, 1, 5, 1); tick();
    set_d(1, 0, 0, 5, 1, 0, 0, 0); tick(); tick();
    chk("lu_stall_cnt", stall_cnt, 1);

    // Writes to $0 never forward or stall.
    set_d(1, 0, 0, 0, 0, 1, 0, 1); repeat (3) tick();
    set_d(1, 0, 1, 0, 1, 0, 0, 0); tick();

    // Branch overrides a simultaneous load-use stall and jump.
    set_d(1, 0, 0, 0, 0, 1, 7, 1); tick();
    set_d(1, 7, 1, 0, 0, 0, 0, 0); d_jmp = 1; e_br_taken = 1; tick();
    d_jmp = 0; e_br_taken = 0;
    chk("br_flush_cnt", flush_cnt, 2);
    chk("br_stall_cnt", stall_cnt, 1);

    // Halt with a full pipe, single step, resume.
    set_d(1, 0, 0, 0, 0, 1, 9, 0); repeat (3) tick();
    halt_req = 1;
    begin
      int n = 0;
      while (!halt_ack && n < 12) begin tick(); n++; end
      chk("halt_reach", halt_ack, 1);
    end
    step_req = 1; tick(); step_req = 0;
    repeat (5) tick();
    chk("halt_after_step", halt_ack, 1);
    halt_req = 0; tick(); tick();

    // Reset while draining.
    set_d(1, 0, 0, 0, 0, 1, 4, 0); tick();
    halt_req = 1; tick(); tick();
    rst = 1; tick(); rst = 0; halt_req = 0;
    chk("rst_halt_ack", halt_ack, 0);
    chk("rst_pc_en",    pc_en,    1);
    chk("rst_stall",    stall_cnt, 0);
    tick();

    // Random traffic with small register range to make hazards frequent.
    for (int c = 0; c < 3000; c++) begin
      set_d($urandom_range(9, 0) != 0, $urandom_range(3, 0), $urandom_range(1, 0),
            $urandom_range(3, 0), $urandom_range(1, 0), $urandom_range(3, 0) != 0,
            $urandom_range(3, 0), $urandom_range(2, 0) == 0);
      d_jmp      = $urandom_range(9, 0) == 0;
      e_br_taken = $urandom_range(11, 0) == 0;
      if ($urandom_range(39, 0) == 0) halt_req = ~halt_req;
      step_req   = $urandom_range(4, 0) == 0;
      rst        = $urandom_range(799, 0) == 0;
      tick();
    end
    rst = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
